line_window_3: RTL and testbench

LINE_WINDOW_3 -- requirements
Module: line_window_3

---
 rtl/stream_pkg.sv | 17 +
 rtl/line_memory.sv | 22 ++
 rtl/line_window_3.sv | 105 ++++++++++
 tb/tb_line_window_3.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared pixel-stream types and default geometry for the 3x3 window front end
// and the kernel stages that consume its windows.
package stream_pkg;

  localparam int DEF_PRECISION = 16;
  localparam int DEF_WIDTH     = 800;
  localparam int DEF_HEIGHT    = 600;

  typedef logic signed [DEF_PRECISION-1:0] pixel_t;
  typedef pixel_t [2:0][2:0]               window3_t;

  // Index width for a counter over n positions; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_memory.sv
// One line of pixel storage: single write port with a combinational read that
// returns the contents as they were before this edge's write.
module line_memory #(
  parameter int DEPTH = 800,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DW-1:0]            i_wdata,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/line_window_3.sv
// Raster-stream 3x3 sliding window with two line memories; flags only windows
// whose nine pixels all lie inside the current frame.
module line_window_3
  import stream_pkg::*;
#(
  parameter int PRECISION = DEF_PRECISION,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic signed [PRECISION-1:0]            pixel_in,
  input  logic                                   pixel_valid,
  input  logic                                   sof,
  output logic signed [2:0][2:0][PRECISION-1:0]  buffer_3,
  output logic                                   window_valid,
  output logic [$clog2(HEIGHT)-1:0]              out_row,
  output logic [$clog2(WIDTH)-1:0]               out_col
);

  localparam int CW = idx_w(WIDTH);
  localparam int RW = idx_w(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic [PRECISION-1:0] w_l1, w_l2;
  logic [2:0][2:0][PRECISION-1:0] r_win, w_win_nxt;
  logic w_interior;

  // sof overrides the counters so the tagged pixel is (0,0) regardless of history.
  always_comb begin
    w_col     = sof ? '0 : r_col;
    w_row     = sof ? '0 : r_row;
    w_col_nxt = w_col + 1'b1;
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
    end
  end

  line_memory #(.DEPTH(WIDTH), .DW(PRECISION)) u_line1 (
    .clk     (clk),
    .i_we    (pixel_valid),
    .i_addr  (w_col),
    .i_wdata (pixel_in),
    .o_rdata (w_l1)
  );

  line_memory #(.DEPTH(WIDTH), .DW(PRECISION)) u_line2 (
    .clk     (clk),
    .i_we    (pixel_valid),
    .i_addr  (w_col),
    .i_wdata (w_l1),
    .o_rdata (w_l2)
  );

  always_comb begin
    w_win_nxt = r_win;
    for (int r = 0; r < 3; r++) begin
      w_win_nxt[r][0] = r_win[r][1];
      w_win_nxt[r][1] = r_win[r][2];
    end
    w_win_nxt[0][2] = w_l2;
    w_win_nxt[1][2] = w_l1;
    w_win_nxt[2][2] = pixel_in;
  end

  assign w_interior = pixel_valid && (w_row >= ROW_TWO) && (w_col >= COL_TWO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_win <= '0;
    end else if (pixel_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      r_win <= w_win_nxt;
    end
  end

  // The running window shifts on every pixel; the output copy only updates on
  // in-frame windows so downstream sees a stable value between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      window_valid <= 1'b0;
      buffer_3     <= '0;
      out_row      <= '0;
      out_col      <= '0;
    end else begin
      window_valid <= w_interior;
      if (w_interior) begin
        buffer_3 <= w_win_nxt;
        out_row  <= w_row - RW'(1);
        out_col  <= w_col - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_line_window_3.sv
// Directed bench for line_window_3 on a 4x4 frame; a raster model predicts each
// in-frame window and a queue scoreboard matches them against the pulses.
module tb_line_window_3;

  typedef logic [2:0][2:0][15:0] win_t;
  typedef struct {
    win_t       win;
    logic [1:0] row;
    logic [1:0] col;
  } exp_t;

  logic                        clk;
  logic                        reset;
  logic signed [15:0]          pixel_in;
  logic                        pixel_valid;
  logic                        sof;
  logic signed [2:0][2:0][15:0] buffer_3;
  logic                        window_valid;
  logic [1:0]                  out_row;
  logic [1:0]                  out_col;

  int   n_tests, n_fail, npulse;
  int   mr, mc;
  logic [15:0] img [4][4];
  exp_t q [$];
  win_t lastwin;
  logic [1:0] lastrow, lastcol;

  line_window_3 #(.PRECISION(16), .WIDTH(4), .HEIGHT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .sof          (sof),
    .buffer_3     (buffer_3),
    .window_valid (window_valid),
    .out_row      (out_row),
    .out_col      (out_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic win_t lit(input int base);
    win_t w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[i][j] = 16'(base + 4 * i + j);
    return w;
  endfunction

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_valid"}, window_valid, 1'b0);
    chk({tag, "_buf"}, $unsigned(buffer_3), '0);
    chk({tag, "_row"}, out_row, 2'd0);
    chk({tag, "_col"}, out_col, 2'd0);
  endtask

  task automatic check_out(input logic ep);
    exp_t e;
    chk("window_valid", window_valid, ep);
    if (window_valid) begin
      npulse++;
      chk("sb_has_entry", logic'(q.size() != 0), 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("win", $unsigned(buffer_3), e.win);
        chk("out_row", out_row, e.row);
        chk("out_col", out_col, e.col);
        lastwin = e.win;
        lastrow = e.row;
        lastcol = e.col;
      end
    end else begin
      chk("held_buf", $unsigned(buffer_3), lastwin);
      chk("held_row", out_row, lastrow);
      chk("held_col", out_col, lastcol);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] val, input logic s);
    exp_t e;
    logic ep;
    @(negedge clk);
    pixel_valid = v;
    pixel_in    = val;
    sof         = s;
    ep          = 1'b0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = val;
      if (mr >= 2 && mc >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[i][j] = img[mr - 2 + i][mc - 2 + j];
        e.row = 2'(mr - 1);
        e.col = 2'(mc - 1);
        q.push_back(e);
        ep = 1'b1;
      end
      if (mc == 3) begin
        mc = 0;
        mr = (mr == 3) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    @(posedge clk);
    #1;
    check_out(ep);
    pixel_valid = 1'b0;
    sof         = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; npulse = 0;
    mr = 0; mc = 0;
    lastwin = '0; lastrow = '0; lastcol = '0;
    reset = 1'b1; pixel_valid = 1'b0; pixel_in = '0; sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single frame, back-to-back pixels.
    npulse = 0;
    for (int v = 0; v <= 10; v++) step(1'b1, 16'(v), v == 0);
    chk("A_first_win", $unsigned(buffer_3), lit(0));
    chk("A_first_row", out_row, 2'd1);
    chk("A_first_col", out_col, 2'd1);
    for (int v = 11; v <= 15; v++) step(1'b1, 16'(v), 1'b0);
    chk("A_last_win", $unsigned(buffer_3), lit(5));
    chk("A_pulses", npulse, 4);

    // Three idle cycles after pixel 9.
    npulse = 0;
    for (int v = 0; v <= 9; v++) step(1'b1, 16'(v), v == 0);
    repeat (3) step(1'b0, 16'hbeef, 1'b0);
    step(1'b1, 16'd10, 1'b0);
    chk("B_first_win", $unsigned(buffer_3), lit(0));
    for (int v = 11; v <= 15; v++) step(1'b1, 16'(v), 1'b0);
    chk("B_pulses", npulse, 4);

    // Two frames back to back, second one relying on counter wrap.
    npulse = 0;
    for (int v = 0; v <= 15; v++) step(1'b1, 16'(v), v == 0);
    for (int v = 100; v <= 109; v++) step(1'b1, 16'(v), 1'b0);
    chk("C_no_early_pulse", npulse, 4);
    step(1'b1, 16'd110, 1'b0);
    chk("C_first_win2", $unsigned(buffer_3), lit(100));
    for (int v = 111; v <= 115; v++) step(1'b1, 16'(v), 1'b0);
    chk("C_pulses", npulse, 8);

    // sof mid-frame on pixel 6 restarts the raster position.
    npulse = 0;
    for (int v = 0; v <= 5; v++) step(1'b1, 16'(v), v == 0);
    for (int v = 6; v <= 15; v++) step(1'b1, 16'(v), v == 6);
    chk("D_no_pulse_yet", npulse, 0);
    step(1'b1, 16'd16, 1'b0);
    chk("D_first_pulse", npulse, 1);
    for (int v = 17; v <= 21; v++) step(1'b1, 16'(v), 1'b0);
    chk("D_pulses", npulse, 4);

    // Asynchronous reset between edges after pixel 11, then a restart without sof.
    for (int v = 0; v <= 11; v++) step(1'b1, 16'(v), v == 0);
    chk("E_sb_drained", q.size(), 0);
    #2;
    reset = 1'b1;
    #1;
    chk_zero_outs("E_async_reset");
    mr = 0; mc = 0;
    lastwin = '0; lastrow = '0; lastcol = '0;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    npulse = 0;
    for (int v = 0; v <= 10; v++) step(1'b1, 16'(v), 1'b0);
    chk("E_first_win", $unsigned(buffer_3), lit(0));
    chk("E_first_row", out_row, 2'd1);
    chk("E_first_col", out_col, 2'd1);
    for (int v = 11; v <= 15; v++) step(1'b1, 16'(v), 1'b0);
    chk("E_last_win", $unsigned(buffer_3), lit(5));
    chk("E_pulses", npulse, 4);
    chk("E_sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
